// File: rtl/clk_div_pkg.sv
// Shared state type and configuration sanitising helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_e;

  function automatic int unsigned sanitise_div(input int unsigned n);
    return (n < DIV_MIN) ? DIV_MIN : n;
  endfunction

  // High time is clamped against the already-sanitised divide ratio.
  function automatic int unsigned sanitise_high(input int unsigned n, input int unsigned h);
    int unsigned div;
    int unsigned high;
    div  = sanitise_div(n);
    high = (h == 0) ? 1 : h;
    if (high >= div) high = div - 1;
    return high;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Run request, configuration handshake and divided-clock outputs of clk_div_prog.
interface clk_div_prog_if #(
  parameter int unsigned W = 8
) ();

  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_div;

  modport master (
    output en, cfg_valid, cfg_div, cfg_high,
    input  cfg_ready, clk_out, tick, busy, cur_div
  );

  modport slave (
    input  en, cfg_valid, cfg_div, cfg_high,
    output cfg_ready, clk_out, tick, busy, cur_div
  );

endinterface

// File: rtl/clk_div_cfg_shadow.sv
// Shadow register for a new divide/high setting: capture handshake, sanitise, pending flag.
module clk_div_cfg_shadow #(
  parameter int unsigned W = 8
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_high,
  input  logic         apply,
  output logic         cfg_ready,
  output logic         pending,
  output logic [W-1:0] sh_div,
  output logic [W-1:0] sh_high
);
  import clk_div_pkg::*;

  logic         ready_q;
  logic         pending_q;
  logic [W-1:0] sh_div_q;
  logic [W-1:0] sh_high_q;
  logic         capture;

  assign capture = cfg_valid && ready_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b1;
      pending_q <= 1'b0;
      sh_div_q  <= W'(DIV_MIN);
      sh_high_q <= W'(1);
    end else begin
      // Ready re-opens only after a full cycle with the shadow drained.
      ready_q <= !capture && !pending_q;
      if (capture) begin
        pending_q <= 1'b1;
        sh_div_q  <= W'(sanitise_div(32'(cfg_div)));
        sh_high_q <= W'(sanitise_high(32'(cfg_div), 32'(cfg_high)));
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign cfg_ready = ready_q;
  assign pending   = pending_q;
  assign sh_div    = sh_div_q;
  assign sh_high   = sh_high_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with one-cycle tick strobe; settings change only at
// period boundaries so clk_out never glitches.
module clk_div_prog #(
  parameter int unsigned W        = 8,
  parameter int unsigned DEF_DIV  = 7,
  parameter int unsigned DEF_HIGH = 3
) (
  input logic           clk_in,
  input logic           rst,
  clk_div_prog_if.slave bus
);
  import clk_div_pkg::*;

  localparam logic [W-1:0] DefDiv  = W'(sanitise_div(DEF_DIV));
  localparam logic [W-1:0] DefHigh = W'(sanitise_high(DEF_DIV, DEF_HIGH));

  state_e       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] div_q;
  logic [W-1:0] high_q;
  logic         clk_out_q;
  logic         tick_q;

  logic         pending;
  logic         apply;
  logic         wrap;
  logic [W-1:0] sh_div;
  logic [W-1:0] sh_high;
  logic [W-1:0] div_nxt;
  logic [W-1:0] high_nxt;
  logic [W-1:0] cnt_nxt;

  clk_div_cfg_shadow #(
    .W (W)
  ) u_shadow (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (bus.cfg_valid),
    .cfg_div   (bus.cfg_div),
    .cfg_high  (bus.cfg_high),
    .apply     (apply),
    .cfg_ready (bus.cfg_ready),
    .pending   (pending),
    .sh_div    (sh_div),
    .sh_high   (sh_high)
  );

  assign wrap     = (state_q != StIdle) && (cnt_q == div_q - W'(1));
  assign apply    = pending && ((state_q == StIdle) || wrap);
  assign div_nxt  = apply ? sh_div : div_q;
  assign high_nxt = apply ? sh_high : high_q;
  assign cnt_nxt  = wrap ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DefDiv;
      high_q    <= DefHigh;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      if (apply) begin
        div_q  <= sh_div;
        high_q <= sh_high;
      end
      unique case (state_q)
        StIdle: begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          // High time is at least one cycle, so the first cycle of a run is always high.
          clk_out_q <= bus.en;
          state_q   <= bus.en ? StRun : StIdle;
        end
        StRun, StStopping: begin
          if (!bus.en && (state_q == StStopping) && wrap) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
          end else begin
            state_q   <= bus.en ? StRun : StStopping;
            cnt_q     <= cnt_nxt;
            clk_out_q <= (cnt_nxt < high_nxt);
            tick_q    <= (cnt_nxt == div_nxt - W'(1));
          end
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
          tick_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.cur_div = div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed and randomized bench for clk_div_prog against a period-level behavioural model.
module tb_clk_div_prog;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  clk_div_prog_if #(.W(8)) bus ();

  clk_div_prog #(
    .W        (8),
    .DEF_DIV  (7),
    .DEF_HIGH (3)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  // Model: position inside the current period plus the settings in force.
  bit          m_busy  = 1'b0;
  bit          m_stop  = 1'b0;
  bit          m_pend  = 1'b0;
  bit          m_ready = 1'b1;
  int unsigned m_pos   = 0;
  int unsigned m_div   = 7;
  int unsigned m_high  = 3;
  int unsigned m_sdiv  = 2;
  int unsigned m_shigh = 1;

  function automatic int unsigned fix_div(input int unsigned n);
    return (n < 2) ? 2 : n;
  endfunction

  function automatic int unsigned fix_high(input int unsigned n, input int unsigned h);
    int unsigned lim;
    lim = fix_div(n) - 1;
    if (h == 0) return 1;
    if (h > lim) return lim;
    return h;
  endfunction

  always @(posedge clk_in or posedge rst) begin : model
    bit period_end;
    bit take;
    bit cap;
    if (rst) begin
      m_busy  = 1'b0;
      m_stop  = 1'b0;
      m_pend  = 1'b0;
      m_ready = 1'b1;
      m_pos   = 0;
      m_div   = 7;
      m_high  = 3;
    end else begin
      period_end = m_busy && (m_pos == m_div - 1);
      take       = m_pend && (!m_busy || period_end);
      cap        = (bus.cfg_valid === 1'b1) && m_ready;
      m_ready    = !cap && !m_pend;
      if (take) m_pend = 1'b0;
      if (cap) begin
        m_pend  = 1'b1;
        m_sdiv  = fix_div(32'(bus.cfg_div));
        m_shigh = fix_high(32'(bus.cfg_div), 32'(bus.cfg_high));
      end
      if (!m_busy) begin
        if (bus.en === 1'b1) begin
          m_busy = 1'b1;
          m_stop = 1'b0;
          m_pos  = 0;
        end
      end else if (period_end && m_stop && (bus.en !== 1'b1)) begin
        m_busy = 1'b0;
        m_pos  = 0;
      end else begin
        m_pos  = period_end ? 0 : m_pos + 1;
        m_stop = (bus.en !== 1'b1);
      end
      if (take) begin
        m_div  = m_sdiv;
        m_high = m_shigh;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    check("model.clk_out", 32'(bus.clk_out), 32'(m_busy && (m_pos < m_high)));
    check("model.tick", 32'(bus.tick), 32'(m_busy && (m_pos == m_div - 1)));
    check("model.busy", 32'(bus.busy), 32'(m_busy));
    check("model.cur_div", 32'(bus.cur_div), m_div);
    check("model.cfg_ready", 32'(bus.cfg_ready), 32'(m_ready));
  end

  task automatic chk_out(input string nm, input bit e_clk, input bit e_tick, input bit e_busy,
                         input int unsigned e_div);
    check({nm, ".clk_out"}, 32'(bus.clk_out), 32'(e_clk));
    check({nm, ".tick"}, 32'(bus.tick), 32'(e_tick));
    check({nm, ".busy"}, 32'(bus.busy), 32'(e_busy));
    check({nm, ".cur_div"}, 32'(bus.cur_div), e_div);
  endtask

  // kind: 0 = busy low, 1 = tick high, 2 = cfg_ready high
  task automatic wait_for(input string nm, input int kind, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk_in);
      case (kind)
        0:       hit = (bus.busy === 1'b0);
        1:       hit = (bus.tick === 1'b1);
        default: hit = (bus.cfg_ready === 1'b1);
      endcase
    end
    if (!hit) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no event within %0d cycles, required one", nm, limit);
    end
  endtask

  task automatic set_cfg(input bit v, input int unsigned d, input int unsigned h);
    bus.cfg_valid = v;
    bus.cfg_div   = 8'(d);
    bus.cfg_high  = 8'(h);
  endtask

  int unsigned p;
  int unsigned rd;
  int unsigned rh;

  initial begin
    bus.en = 1'b0;
    set_cfg(1'b0, 0, 0);
    #1 rst = 1'b1;
    @(negedge clk_in);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 7);
    check("reset.cfg_ready", 32'(bus.cfg_ready), 32'd1);
    rst = 1'b0;

    // Default 7/3 run.
    @(negedge clk_in);
    bus.en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_in);
      chk_out("def_run", (i % 7) < 3, (i % 7) == 6, 1'b1, 7);
    end

    // New setting offered mid-period lands at the following wrap.
    @(negedge clk_in);
    @(negedge clk_in);
    set_cfg(1'b1, 4, 2);
    @(negedge clk_in);
    set_cfg(1'b0, 0, 0);
    check("cfg_mid.ready_low", 32'(bus.cfg_ready), 32'd0);
    for (int k = 0; k < 13; k++) begin
      if (k < 5) begin
        p = k + 2;
        chk_out("cfg_mid.old", p < 3, p == 6, 1'b1, 7);
      end else begin
        p = (k - 5) % 4;
        chk_out("cfg_mid.new", p < 2, p == 3, 1'b1, 4);
      end
      if (k == 4) check("cfg_mid.ready_pend", 32'(bus.cfg_ready), 32'd0);
      if (k == 5) check("cfg_mid.ready_gap", 32'(bus.cfg_ready), 32'd0);
      if (k == 6) check("cfg_mid.ready_back", 32'(bus.cfg_ready), 32'd1);
      @(negedge clk_in);
    end

    // Out-of-range setting applied in IDLE is sanitised to 2/1.
    bus.en = 1'b0;
    wait_for("stop_n4", 0, 20);
    check("idle.ready", 32'(bus.cfg_ready), 32'd1);
    set_cfg(1'b1, 1, 5);
    @(negedge clk_in);
    set_cfg(1'b0, 0, 0);
    check("idle_cfg.ready_low", 32'(bus.cfg_ready), 32'd0);
    @(negedge clk_in);
    check("idle_cfg.cur_div", 32'(bus.cur_div), 32'd2);
    bus.en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      chk_out("n2_run", (k % 2) == 0, (k % 2) == 1, 1'b1, 2);
    end
    bus.en = 1'b0;
    wait_for("stop_n2", 0, 20);
    wait_for("ready_n2", 2, 20);
    set_cfg(1'b1, 7, 3);
    @(negedge clk_in);
    set_cfg(1'b0, 0, 0);
    wait_for("ready_n7", 2, 20);
    check("restore.cur_div", 32'(bus.cur_div), 32'd7);

    // Stop requested at cnt=1: period finishes with its tick, then IDLE.
    bus.en = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    bus.en = 1'b0;
    for (p = 2; p < 7; p++) begin
      @(negedge clk_in);
      chk_out("stop", p < 3, p == 6, 1'b1, 7);
    end
    @(negedge clk_in);
    chk_out("stop.idle", 1'b0, 1'b0, 1'b0, 7);

    // Stop withdrawn at cnt=4: no gap.
    bus.en = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    bus.en = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    bus.en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      p = (5 + k) % 7;
      chk_out("rearm", p < 3, p == 6, 1'b1, 7);
    end

    // Capture in the wrap cycle waits a full period.
    wait_for("tick_wrapcap", 1, 20);
    check("wrapcap.ready", 32'(bus.cfg_ready), 32'd1);
    set_cfg(1'b1, 3, 1);
    @(negedge clk_in);
    set_cfg(1'b0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (k < 7) chk_out("wrapcap.old", k < 3, k == 6, 1'b1, 7);
      else chk_out("wrapcap.new", k == 7, k == 9, 1'b1, 3);
      @(negedge clk_in);
    end

    // Asynchronous reset in a high phase with a setting pending.
    wait_for("tick_rst", 1, 20);
    set_cfg(1'b1, 5, 2);
    @(posedge clk_in);
    #1;
    set_cfg(1'b0, 0, 0);
    check("rst.pre_clk_out", 32'(bus.clk_out), 32'd1);
    check("rst.pre_ready", 32'(bus.cfg_ready), 32'd0);
    #1;
    rst    = 1'b1;
    bus.en = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 1'b0, 7);
    check("rst.async_ready", 32'(bus.cfg_ready), 32'd1);
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("rst.discard", 32'(bus.cur_div), 32'd7);

    // Randomized traffic; the model compare checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 23) == 0) bus.en = !bus.en;
      case ($urandom_range(0, 7))
        0:       rd = 0;
        1:       rd = 1;
        2:       rd = 2;
        3:       rd = 255;
        default: rd = $urandom_range(2, 20);
      endcase
      rh = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
      set_cfg($urandom_range(0, 5) == 0, rd, rh);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        #6 rst = 1'b0;
      end
    end
    @(negedge clk_in);
    set_cfg(1'b0, 0, 0);
    bus.en = 1'b0;
    wait_for("final_stop", 0, 600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Programmable integer clock divider and strobe generator. It is the parametrised successor to the fixed divide-by-7 divider and produces a divided clock of runtime-selectable period and high time, plus a one-cycle tick strobe. Divide and duty settings change only at period boundaries, so the output never glitches. It sits between the SoC clock source and slow peripherals (UART baud, timer prescale, debug clocks).

Parameters:
W, 8, width of the divide and high-time counters.
DEF_DIV, 7, active divide ratio after reset.
DEF_HIGH, 3, active high-time (cycles) after reset.

Ports:
clk_in  in  1  single system clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
en  in  1  run request; level-sensitive.
cfg_valid  in  1  new configuration offered.
cfg_ready  out  1  shadow register free; capture when cfg_valid && cfg_ready.
cfg_div  in  W  requested divide ratio N.
cfg_high  in  W  requested high time H, in clk_in cycles.
clk_out  out  1  divided clock, registered.
tick  out  1  one-cycle strobe in the last cycle of each period.
busy  out  1  high in RUN or STOPPING.
cur_div  out  W  active (applied) divide ratio.

Behaviour:
- Reset values:
  - clk_out=0, tick=0, busy=0, cfg_ready=1.
  - cnt=0, state=IDLE, shadow pending=0.
  - Active div=DEF_DIV and high=DEF_HIGH, both sanitised; cur_div=DEF_DIV.
- Sanitise at capture:
  - N<2 becomes 2.
  - H==0 becomes 1.
  - H>=N becomes N-1.
- Config handshake:
  - Capture into the shadow on cfg_valid && cfg_ready. In that cycle pending=1, and cfg_ready=0 from the next cycle.
  - In IDLE, a pending shadow is applied on the next clock; cfg_ready returns to 1 the cycle after apply.
  - In RUN/STOPPING, the shadow is applied only at a wrap edge (cnt==div-1), and only if pending was already 1 at the start of that cycle.
  - A capture in the wrap cycle itself waits for the following wrap.
- State machine:
  - IDLE: cnt=0, clk_out=0. When en=1 is sampled, go to RUN. The next cycle has cnt=0 and clk_out=1.
  - RUN: cnt increments, wrapping from div-1 to 0.
    - clk_out=1 while cnt<high, else 0.
    - tick=1 while cnt==div-1.
    - When en=0 is sampled, go to STOPPING.
  - STOPPING: keeps counting exactly as in RUN.
    - If en=1 is sampled, return to RUN with no discontinuity.
    - At the wrap edge, go to IDLE with clk_out=0 and cnt=0.
    - The final tick is still issued.
- Boundaries:
  - A stop never truncates a high phase or a period.
  - With N=2, H=1: clk_out toggles every cycle and tick fires every 2nd cycle.
  - With N=2^W-1, cnt must not overflow.
  - A new config applied at a wrap takes effect with cnt=0 of the next period, using the new high.
- Reset mid-period: all state clears asynchronously and immediately; the shadow is discarded.
- busy = (state != IDLE).

Decomposition:
- Package clk_div_pkg holds:
  - state enum {IDLE, RUN, STOPPING};
  - the sanitise function;
  - DIV_MIN=2.
- One natural sub-module, clk_div_cfg_shadow:
  - capture handshake;
  - sanitise;
  - pending flag;
  - apply strobe input.
- The core holds the FSM, counter and outputs.

Test Plan:
- Reset defaults, then en=1 → period 7; clk_out high for 3 cycles, low for 4; tick in the 7th cycle of each period; cur_div=7.
- While running, cfg N=4, H=2 mid-period → current 7-cycle period completes unchanged; next period is 4 cycles with 2 high; cfg_ready low until one cycle after apply.
- cfg N=1, H=5 in IDLE → sanitised to N=2, H=1; en=1 gives clk_out toggling every cycle; cur_div=2.
- en=1→0 at cnt=1 with N=7 → output continues to cnt=6 with final tick, then IDLE with clk_out=0 and busy=0; re-asserting en at cnt=4 instead → no gap, stays in RUN.
- cfg captured exactly in a wrap cycle → the next period still uses the old setting; the change lands one period later.
- rst asserted asynchronously mid-high-phase with a pending cfg → clk_out=0 immediately; defaults (7/3) restored; pending cleared; cfg_ready=1.
